// File: rtl/register_dump_unit_pkg.sv
// Shared state encoding and constants for the register dump unit.
// REG_DUMP_HEADER_EN adds a HEADER state that emits HEADER_BYTE ahead of the register words.
package register_dump_unit_pkg;

  localparam int DEF_NB_DATA = 32;
  localparam int DEF_NB_REG  = 5;
  localparam int DEF_NB_BYTE = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SEND   = 3'd2,
    ST_DONE   = 3'd3
`ifdef REG_DUMP_HEADER_EN
    , ST_HEADER = 3'd4
`endif
  } dump_state_e;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  function automatic int bytes_per_word(input int nb_data, input int nb_byte);
    return nb_data / nb_byte;
  endfunction

  // A one-byte word still needs a 1-bit counter to keep the select legal.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BYTES_PER_WORD = bytes_per_word(DEF_NB_DATA, DEF_NB_BYTE);

endpackage

// File: rtl/register_dump_unit_if.sv
// Bus between the dump unit and its environment: start, register-bank read port and byte stream.
interface register_dump_unit_if
  import register_dump_unit_pkg::*;
#(
  parameter int NB_DATA = DEF_NB_DATA,
  parameter int NB_REG  = DEF_NB_REG,
  parameter int NB_BYTE = DEF_NB_BYTE
);
  logic               i_start;
  logic [NB_REG-1:0]  o_read_reg;
  logic [NB_DATA-1:0] i_register;
  logic [NB_BYTE-1:0] o_data;
  logic               o_valid;
  logic               i_ready;
  logic               o_busy;
  logic               o_done;

  modport slave (
    input  i_start, i_register, i_ready,
    output o_read_reg, o_data, o_valid, o_busy, o_done
  );

  modport master (
    output i_start, i_register, i_ready,
    input  o_read_reg, o_data, o_valid, o_busy, o_done
  );
endinterface

// File: rtl/register_dump_unit_word_serializer.sv
// Word serializer: captures one register word and offers it LSB byte first under valid/ready.
// The byte on offer only moves on a handshake, so a stalled sink sees a stable byte.
module register_dump_unit_word_serializer
  import register_dump_unit_pkg::*;
#(
  parameter int NB_DATA = DEF_NB_DATA,
  parameter int NB_BYTE = DEF_NB_BYTE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [NB_DATA-1:0] word,
  input  logic               valid,
  input  logic               ready,
  output logic [NB_BYTE-1:0] o_byte,
  output logic               last_xfer
);
  localparam int BPW   = bytes_per_word(NB_DATA, NB_BYTE);
  localparam int CNT_W = cnt_width(BPW);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BPW - 1);

  logic [NB_DATA-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NB_BYTE-1:0] lanes [BPW];
  logic               xfer;

  genvar gi;
  generate
    for (gi = 0; gi < BPW; gi++) begin : g_lane
      assign lanes[gi] = shift_q[gi*NB_BYTE +: NB_BYTE];
    end
  endgenerate

  assign xfer      = valid & ready;
  assign last_xfer = xfer && (cnt_q == LAST_CNT);
  assign o_byte    = lanes[cnt_q];

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load) begin
      shift_d = word;
      cnt_d   = '0;
    end else if (xfer) begin
      cnt_d = last_xfer ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/register_dump_unit.sv
// Register dump unit: walks every register of the bank and streams each word out LSB byte first.
// Define REG_DUMP_HEADER_EN to prefix the whole dump with one HEADER_BYTE.
module register_dump_unit
  import register_dump_unit_pkg::*;
#(
  parameter int NB_DATA = DEF_NB_DATA,
  parameter int NB_REG  = DEF_NB_REG,
  parameter int NB_BYTE = DEF_NB_BYTE
) (
  input logic                 i_clk,
  input logic                 i_reset,
  register_dump_unit_if.slave bus
);
  localparam logic [NB_REG-1:0] LAST_IDX = '1;
`ifdef REG_DUMP_HEADER_EN
  localparam dump_state_e FIRST_STATE = ST_HEADER;
`else
  localparam dump_state_e FIRST_STATE = ST_LOAD;
`endif

  dump_state_e        state_q, state_d;
  logic [NB_REG-1:0]  idx_q, idx_d;
  logic               load;
  logic               ser_valid;
  logic               hdr_valid;
  logic               last_xfer;
  logic [NB_BYTE-1:0] ser_byte;

  register_dump_unit_word_serializer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_word_serializer (
    .clk       (i_clk),
    .rst_n     (i_reset),
    .load      (load),
    .word      (bus.i_register),
    .valid     (ser_valid),
    .ready     (bus.i_ready),
    .o_byte    (ser_byte),
    .last_xfer (last_xfer)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    load      = 1'b0;
    ser_valid = 1'b0;
    hdr_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          idx_d   = '0;
          state_d = FIRST_STATE;
        end
      end
`ifdef REG_DUMP_HEADER_EN
      ST_HEADER: begin
        hdr_valid = 1'b1;
        if (bus.i_ready) state_d = ST_LOAD;
      end
`endif
      ST_LOAD: begin
        load    = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        ser_valid = 1'b1;
        if (last_xfer) begin
          // The index wraps to 0 after the final register so the next dump starts clean.
          idx_d   = idx_q + NB_REG'(1);
          state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_LOAD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.o_read_reg = idx_q;
  assign bus.o_valid    = ser_valid | hdr_valid;
  assign bus.o_data     = hdr_valid ? NB_BYTE'(HEADER_BYTE) : (ser_valid ? ser_byte : '0);
  assign bus.o_busy     = (state_q != ST_IDLE);
  assign bus.o_done     = (state_q == ST_DONE);
endmodule

// File: tb/tb_register_dump_unit.sv
// Bench for register_dump_unit: byte-stream model built from the bank contents, checked every cycle.
// Build with REG_DUMP_HEADER_EN defined to exercise the header variant.
module tb_register_dump_unit;
  import register_dump_unit_pkg::*;

  localparam int NB_DATA = 32;
  localparam int NB_REG  = 5;
  localparam int NB_BYTE = 8;
  localparam int NREGS   = 1 << NB_REG;
  localparam int BPW     = BYTES_PER_WORD;
`ifdef REG_DUMP_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic i_clk = 1'b0;
  logic i_reset;

  register_dump_unit_if #(.NB_DATA(NB_DATA), .NB_REG(NB_REG), .NB_BYTE(NB_BYTE)) bus ();

  register_dump_unit #(.NB_DATA(NB_DATA), .NB_REG(NB_REG), .NB_BYTE(NB_BYTE)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  logic [NB_DATA-1:0] bank [NREGS];
  assign bus.i_register = bank[bus.o_read_reg];

  logic [7:0] exp_q [$];
  logic [7:0] act [256];
  int total = 0;
  int bad = 0;
  int ptr = 0;
  int done_cnt = 0;
  bit active = 1'b0;
  bit prev_hold = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic chk(input bit ok, input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Compare process: sampled on the falling edge, away from the active edge.
  always @(negedge i_clk) begin
    if (!i_reset) begin
      active    = 1'b0;
      ptr       = 0;
      prev_hold = 1'b0;
    end else if (!active) begin
      chk(bus.o_valid == 1'b0, "idle_valid", 32'(bus.o_valid), 0);
      chk(bus.o_busy == 1'b0, "idle_busy", 32'(bus.o_busy), 0);
      chk(bus.o_done == 1'b0, "idle_done", 32'(bus.o_done), 0);
      if (bus.i_start) begin
        active   = 1'b1;
        ptr      = 0;
        done_cnt = 0;
      end
    end else begin
      chk(bus.o_busy == 1'b1, "active_busy", 32'(bus.o_busy), 1);
      if (prev_hold) begin
        chk(bus.o_valid == 1'b1, "hold_valid", 32'(bus.o_valid), 1);
        chk(bus.o_data == prev_data, "hold_data", 32'(bus.o_data), 32'(prev_data));
      end
      if (bus.o_valid) begin
        chk(ptr < exp_q.size(), "overrun", ptr, exp_q.size());
        if (ptr < exp_q.size())
          chk(bus.o_data == exp_q[ptr], "byte", 32'(bus.o_data), 32'(exp_q[ptr]));
        if (ptr >= HDR)
          chk(bus.o_read_reg == NB_REG'((ptr - HDR) / BPW), "read_reg",
              32'(bus.o_read_reg), (ptr - HDR) / BPW);
        if (bus.i_ready) begin
          act[ptr] = bus.o_data;
          ptr++;
        end
      end
      prev_hold = bus.o_valid && !bus.i_ready;
      prev_data = bus.o_data;
      if (bus.o_done) begin
        done_cnt++;
        chk(ptr == exp_q.size(), "done_at_end", ptr, exp_q.size());
        chk(bus.o_valid == 1'b0, "done_valid", 32'(bus.o_valid), 0);
        active = 1'b0;
      end
    end
  end

  task automatic step(input bit toggle);
    @(posedge i_clk);
    #1;
    bus.i_ready = toggle ? ~bus.i_ready : 1'b1;
  endtask

  task automatic start_dump();
    bus.i_start = 1'b1;
    @(posedge i_clk);
    #1;
    bus.i_start = 1'b0;
`ifdef REG_DUMP_HEADER_EN
    chk(bus.o_valid == 1'b1, "lat_hdr_valid", 32'(bus.o_valid), 1);
    chk(bus.o_data == 8'hA5, "lat_hdr_data", 32'(bus.o_data), 32'hA5);
`else
    chk(bus.o_valid == 1'b0, "lat_load_valid", 32'(bus.o_valid), 0);
    chk(bus.o_read_reg == 0, "lat_load_reg", 32'(bus.o_read_reg), 0);
    @(posedge i_clk);
    #1;
    chk(bus.o_valid == 1'b1, "lat_first_valid", 32'(bus.o_valid), 1);
    chk(bus.o_data == 8'hA5, "lat_first_data", 32'(bus.o_data), 32'hA5);
`endif
  endtask

  task automatic wait_bytes(input int n);
    int k = 0;
    while (ptr < n && k < 2000) begin
      step(1'b0);
      k++;
    end
    chk(ptr >= n, "bytes_timeout", ptr, n);
  endtask

  task automatic wait_done(input bit toggle);
    int k = 0;
    while (done_cnt == 0 && k < 3000) begin
      step(toggle);
      k++;
    end
    chk(done_cnt > 0, "done_timeout", done_cnt, 1);
    step(1'b0);
    step(1'b0);
    chk(done_cnt == 1, "done_pulses", done_cnt, 1);
    chk(ptr == NREGS * BPW + HDR, "byte_total", ptr, NREGS * BPW + HDR);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk(bus.o_read_reg == 0, {tag, "_read_reg"}, 32'(bus.o_read_reg), 0);
    chk(bus.o_data == 0, {tag, "_data"}, 32'(bus.o_data), 0);
    chk(bus.o_valid == 1'b0, {tag, "_valid"}, 32'(bus.o_valid), 0);
    chk(bus.o_busy == 1'b0, {tag, "_busy"}, 32'(bus.o_busy), 0);
    chk(bus.o_done == 1'b0, {tag, "_done"}, 32'(bus.o_done), 0);
  endtask

  task automatic check_pins();
    for (int b = 0; b < 4; b++) begin
      chk(act[HDR + b] == 8'hA5, "pin_reg0", 32'(act[HDR + b]), 32'hA5);
      chk(act[HDR + 28 + b] == 8'hA3, "pin_reg7", 32'(act[HDR + 28 + b]), 32'hA3);
    end
    chk(act[HDR + 4] == 8'h01, "pin_reg1_b0", 32'(act[HDR + 4]), 32'h01);
    chk(act[HDR + 5] == 8'h00, "pin_reg1_b1", 32'(act[HDR + 5]), 32'h00);
    chk(act[HDR + 124] == 8'h1F, "pin_reg31_b0", 32'(act[HDR + 124]), 32'h1F);
  endtask

  initial begin
    for (int r = 0; r < NREGS; r++) bank[r] = NB_DATA'(r);
    bank[0] = 32'hA5A5A5A5;
    bank[7] = 32'hA3A3A3A3;
    if (HDR != 0) exp_q.push_back(8'hA5);
    for (int r = 0; r < NREGS; r++)
      for (int b = 0; b < BPW; b++)
        exp_q.push_back(bank[r][b*NB_BYTE +: NB_BYTE]);

    i_reset     = 1'b0;
    bus.i_start = 1'b0;
    bus.i_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check_reset_outputs("rst");
    i_reset = 1'b1;
    step(1'b0);

    // Full dump with the sink always ready.
    start_dump();
    wait_done(1'b0);
    check_pins();

    // Sink stalls every other cycle.
    start_dump();
    wait_done(1'b1);
    check_pins();

    // A second start mid-dump must be ignored.
    bus.i_ready = 1'b1;
    start_dump();
    wait_bytes(HDR + 10);
    bus.i_start = 1'b1;
    step(1'b0);
    bus.i_start = 1'b0;
    wait_done(1'b0);

    // Reset after 50 bytes, then a fresh dump from register 0.
    start_dump();
    wait_bytes(50);
    i_reset = 1'b0;
    step(1'b0);
    i_reset = 1'b1;
    check_reset_outputs("midrst");
    step(1'b0);
    start_dump();
    wait_done(1'b0);
    check_pins();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/register_dump_unit.md
REGISTER_DUMP_UNIT -- requirements
Module: register_dump_unit

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 32, meaning register width in bits.
REQ-002 The block SHALL have parameter NB_REG, default 5, meaning register-index width (2^NB_REG registers).
REQ-003 The block SHALL have parameter NB_BYTE, default 8, meaning output symbol width.
REQ-004 The block SHALL have port i_clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port i_reset  input  1  meaning synchronous, active-low reset (asserted at 0).
REQ-006 The block SHALL have port i_start  input  1  meaning single-cycle request to dump all registers.
REQ-007 The block SHALL have port o_read_reg  output  NB_REG  meaning read address driven to the register bank second read port.
REQ-008 The block SHALL have port i_register  input  NB_DATA  meaning combinational read data returned for o_read_reg.
REQ-009 The block SHALL have port o_data  output  NB_BYTE  meaning current byte offered downstream (UART TX).
REQ-010 The block SHALL have port o_valid  output  1  meaning o_data holds a byte to transfer.
REQ-011 The block SHALL have port i_ready  input  1  meaning downstream accepts o_data this cycle.
REQ-012 The block SHALL have port o_busy  output  1  meaning a dump is in progress.
REQ-013 The block SHALL have port o_done  output  1  meaning one-cycle pulse after the last byte transfers.

Function
REQ-014 States SHALL be IDLE, LOAD, SEND, DONE (plus HEADER, see Configuration).
REQ-015 IDLE: i_start=1 SHALL move to LOAD with register index 0; i_start outside IDLE SHALL be ignored.
REQ-016 LOAD: o_read_reg SHALL equal the index; i_register SHALL be captured into a NB_DATA shift register at the edge ending LOAD; next state SEND, byte counter 0.
REQ-017 SEND: o_valid SHALL be 1; o_data SHALL be the captured word's byte selected by the counter, least-significant byte first.
REQ-018 A byte SHALL transfer only on an edge with o_valid=1 and i_ready=1; with i_ready=0, o_data and o_valid SHALL hold unchanged.
REQ-019 After byte NB_DATA/NB_BYTE-1 transfers: index < 2^NB_REG-1 SHALL increment index and go to LOAD; index = 2^NB_REG-1 SHALL go to DONE, index wrapping to 0.
REQ-020 DONE SHALL last exactly one cycle with o_done=1, then return to IDLE.
REQ-021 o_busy SHALL be 1 in every state except IDLE.
REQ-022 First o_valid SHALL assert two cycles after i_start is sampled (IDLE->LOAD->SEND); each register costs one LOAD cycle plus four handshakes.
REQ-023 Default total SHALL be 128 bytes for 32x32-bit registers.

Reset
REQ-024 i_reset=0 at a rising edge SHALL force IDLE, index 0, counter 0, shift register 0, regardless of state, including mid-dump.
REQ-025 Reset values: o_read_reg=0, o_data=0, o_valid=0, o_busy=0, o_done=0.
REQ-026 A dump interrupted by reset SHALL NOT resume; a fresh i_start SHALL restart from register 0.

Configuration
REQ-027 Macro REG_DUMP_HEADER_EN SHALL select header emission.
REQ-028 Defined: i_start SHALL go IDLE->HEADER, presenting o_data=8'hA5 with o_valid=1 until handshake, then LOAD; total 129 bytes, first o_valid one cycle after start.
REQ-029 Undefined: HEADER SHALL not exist; behaviour per REQ-015..REQ-023.

Structure
REQ-030 Shared package SHALL hold state encoding, header constant 8'hA5, and bytes-per-word constant NB_DATA/NB_BYTE.
REQ-031 One sub-module, word_serializer (load, byte select, valid/ready hold), SHALL be instantiated; FSM and index counter stay in the top.

Verification
REQ-032 Bank preloaded reg0=32'hA5A5A5A5, reg7=32'hA3A3A3A3, others = index; i_start, i_ready=1 -> bytes A5,A5,A5,A5 first; bytes 28..31 = A3,A3,A3,A3; 128 bytes, o_done one pulse.
REQ-033 i_ready toggled 0/1 every cycle -> o_data stable while i_ready=0; byte sequence identical to REQ-032.
REQ-034 i_reset=0 for one cycle after 50 bytes -> next cycle all outputs 0, IDLE; new i_start -> first byte = reg0 byte0.
REQ-035 i_start pulsed again mid-dump at byte 10 -> ignored; total remains 128 bytes, single o_done.
REQ-036 Build with REG_DUMP_HEADER_EN -> first byte 8'hA5 one cycle after start, 129 bytes, reg0 byte0 second.
